// File: rtl/or_result_serializer.sv
// Captures four OR-stage lane results plus a lane mask, then emits the selected
// lanes one beat per handshake in ascending lane order, counting completed frames.
module or_result_serializer #(
  parameter int BITS = 32,
  localparam int W = BITS + 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [BITS-1:0] c0,
  input  logic [BITS:0]   c1,
  input  logic [BITS+1:0] c2,
  input  logic [BITS+2:0] c3,
  input  logic [3:0]      lane_mask,
  input  logic            in_valid,
  output logic            in_ready,
  output logic [W-1:0]    out_data,
  output logic [1:0]      out_idx,
  output logic            out_last,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [15:0]     frame_cnt
);

  typedef enum logic {IDLE, SEND} state_t;

  state_t              state_q, state_d;
  logic [3:0][W-1:0]   lane_q, lane_d;
  logic [3:0]          mask_q, mask_d;
  logic [1:0]          idx_q, idx_d;
  logic [15:0]         cnt_q, cnt_d;

  logic [1:0]          first_idx;
  logic [1:0]          next_idx;
  logic                has_next;
  logic [15:0]         cnt_inc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      lane_q  <= '0;
      mask_q  <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      lane_q  <= lane_d;
      mask_q  <= mask_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
    end
  end

  // Descending scans so the lowest qualifying lane is the one left assigned.
  always_comb begin
    first_idx = 2'd0;
    next_idx  = idx_q;
    has_next  = 1'b0;
    for (int i = 3; i >= 0; i--) begin
      if (lane_mask[i]) first_idx = 2'(i);
      if (mask_q[i] && (i > int'(idx_q))) begin
        next_idx = 2'(i);
        has_next = 1'b1;
      end
    end
  end

  assign cnt_inc = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;

  always_comb begin
    state_d = state_q;
    lane_d  = lane_q;
    mask_d  = mask_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          lane_d = {W'(c3), W'(c2), W'(c1), W'(c0)};
          mask_d = lane_mask;
          idx_d  = first_idx;
          if (lane_mask != 4'd0) state_d = SEND;
          else                   cnt_d   = cnt_inc;
        end
      end
      SEND: begin
        if (out_ready) begin
          if (has_next) begin
            idx_d = next_idx;
          end else begin
            state_d = IDLE;
            cnt_d   = cnt_inc;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == SEND);
  assign out_data  = out_valid ? lane_q[idx_q] : '0;
  assign out_idx   = out_valid ? idx_q : 2'd0;
  assign out_last  = out_valid && !has_next;
  assign frame_cnt = cnt_q;

endmodule

// File: doc/or_result_serializer.md
OR_RESULT_SERIALIZER -- requirements
Module: or_result_serializer

Interface
REQ-001 SHALL have parameter BITS, default 32, meaning width of lane 0; lane i (i=0..3) is BITS+i bits wide.
REQ-002 SHALL define W = BITS+3 as the output beat width.
REQ-003 SHALL have clk  input  1  sole clock, all state updates on rising edge.
REQ-004 SHALL have rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have c0  input  BITS  lane 0 result from the upstream OR-gate stage.
REQ-006 SHALL have c1  input  BITS+1  lane 1 result.
REQ-007 SHALL have c2  input  BITS+2  lane 2 result.
REQ-008 SHALL have c3  input  BITS+3  lane 3 result.
REQ-009 SHALL have lane_mask  input  4  bit i=1 selects lane i for emission.
REQ-010 SHALL have in_valid  input  1  c0..c3 and lane_mask are valid.
REQ-011 SHALL have in_ready  output  1  block can capture a frame.
REQ-012 SHALL have out_data  output  W  current beat, lane value zero-extended to W.
REQ-013 SHALL have out_idx  output  2  lane number of current beat.
REQ-014 SHALL have out_last  output  1  current beat is last selected lane of frame.
REQ-015 SHALL have out_valid  output  1  beat is valid.
REQ-016 SHALL have out_ready  input  1  downstream accepts beat.
REQ-017 SHALL have frame_cnt  output  16  count of completed frames, saturating at 0xFFFF.

Function
REQ-018 SHALL implement a two-state FSM: IDLE and SEND.
REQ-019 In IDLE, in_ready SHALL be 1 and out_valid SHALL be 0; in SEND, in_ready SHALL be 0.
REQ-020 Capture SHALL occur on a cycle with in_valid=1 and in_ready=1: c0..c3 registered zero-extended to W, lane_mask registered.
REQ-021 On capture with nonzero lane_mask, FSM SHALL enter SEND; first beat (lowest set mask bit) SHALL present out_valid=1 on the next cycle (1-cycle latency).
REQ-022 On capture with lane_mask=0, FSM SHALL stay IDLE, emit no beats, and increment frame_cnt.
REQ-023 Beats SHALL be emitted in ascending lane order, skipping unselected lanes, one beat per accepted handshake.
REQ-024 A beat SHALL transfer when out_valid=1 and out_ready=1; until then out_data, out_idx, out_last SHALL hold stable.
REQ-025 After a transfer with out_last=0, the next selected lane SHALL be presented the following cycle with no bubble.
REQ-026 After a transfer with out_last=1, FSM SHALL return to IDLE, increment frame_cnt, and in_ready SHALL be 1 the following cycle.
REQ-027 out_last SHALL be 1 exactly when no higher-numbered mask bit than out_idx is set.
REQ-028 frame_cnt SHALL hold at 0xFFFF once reached; no wrap.
REQ-029 Inputs c0..c3 and lane_mask SHALL be ignored while in SEND; no frame overlap.
REQ-030 Upstream OR results SHALL be treated as combinational; the block SHALL contain no feedback to c inputs.

Reset
REQ-031 When rst=1 at a clock edge, FSM SHALL go to IDLE, frame_cnt=0, out_valid=0, out_data=0, out_idx=0, out_last=0, held registers and mask cleared.
REQ-032 Reset mid-SEND SHALL abort the frame without increment of frame_cnt; no partial beats after reset.
REQ-033 rst SHALL have priority over any simultaneous capture or transfer.

Verification
REQ-034 BITS=32, capture c0=0x1, c1=0x1_0000_0000, c2=0x3_FFFF_FFFF, c3=0x7_0000_0001, mask=0xF, out_ready=1 -> 4 beats on consecutive cycles, idx 0,1,2,3, data exactly those values, out_last only on idx 3, frame_cnt=1.
REQ-035 mask=0b1010, out_ready=1 -> beats idx 1 then idx 3, out_last on idx 3 only; frame_cnt increments by 1.
REQ-036 mask=0b0100, out_ready held 0 for 5 cycles then 1 -> beat idx 2 stable all 5 cycles with out_last=1, transfers once, in_ready=1 next cycle.
REQ-037 mask=0 with in_valid=1 -> no out_valid, in_ready stays 1, frame_cnt+1; in_valid held during SEND -> no second capture until return to IDLE.
REQ-038 rst=1 asserted after second beat of mask=0xF frame -> out_valid=0 next cycle, frame_cnt=0, next capture starts clean at lowest set lane.
REQ-039 frame_cnt forced near limit via 65536 mask=0 frames -> frame_cnt saturates at 0xFFFF.
